key_schedule: RTL and testbench
===============================

Name: key_schedule

Overview:
- Sequential round-key generator that sits directly upstream of the single-round encoder and drives its in_key input.
- Latches a 16-bit cipher key and expands it with the Mini-AES nibble key schedule.
- Emits round keys K0..K_NUM_ROUNDS in order over a valid/ready stream.
- The round sequencer consumes one key per encoder round.

Parameters:
- NUM_ROUNDS, 2, number of expanded round keys after K0; legal range 1..8.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- start  input  1  request expansion of in_key; sampled only in IDLE
- in_key  input  16  cipher key, sampled in the cycle start is accepted
- rk_valid  output  1  round_key/round_idx are valid
- rk_ready  input  1  consumer accepts the current key
- round_key  output  16  current round key, nibbles w[4r]..w[4r+3], MSB first
- round_idx  output  4  index r of round_key, 0..NUM_ROUNDS
- busy  output  1  high from start acceptance until the final key handshake completes
- done  output  1  one-cycle pulse in the cycle after the final handshake

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, rk_valid=0, round_key=0, round_idx=0, busy=0, done=0.
- Reset mid-expansion aborts immediately; no key is emitted after reset release until a new start.
- States are IDLE, EMIT, FINISH.
- IDLE, start=1: latch in_key into the key register, round_idx<=0, rk_valid<=1, busy<=1, go to EMIT.
  - Latency from start to first valid is one cycle; K0 equals in_key.
- EMIT: round_key, round_idx and rk_valid hold stable until a handshake (rk_valid && rk_ready).
- On a handshake with round_idx<NUM_ROUNDS: the key register loads the next key and round_idx increments; rk_valid stays 1.
  - Back-to-back keys are therefore possible, one per cycle while rk_ready=1.
- On a handshake with round_idx==NUM_ROUNDS: rk_valid<=0, busy<=0, go to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE. round_key and round_idx keep their last values.
- start while busy or in FINISH: ignored, no effect on the sequence.
- start in the same cycle FINISH returns to IDLE: not accepted; it must be asserted again in IDLE.
- rk_ready while rk_valid=0: ignored.
- Next-key arithmetic, from current key nibbles w0..w3 and round number n=round_idx+1 (all 4-bit XOR, no carries):
  - w4 = w0 ^ SBOX(w3) ^ RCON[n]
  - w5 = w1 ^ w4
  - w6 = w2 ^ w5
  - w7 = w3 ^ w6
  - next round_key = {w4,w5,w6,w7}
- SBOX is the team's existing 4-bit s_box (Mini-AES table, e.g. 0->E, F->7).
- RCON[n] for n=1..8: 1,2,4,8,3,6,C,B (successive powers of x in GF(2^4), polynomial x^4+x+1).
- Only one SBOX evaluation per round key; the path is purely combinational from the key register into the register input.

Decomposition:
- Shared package:
  - RCON table
  - MAX_ROUNDS=8
  - KEY_W=16, NIB_W=4
  - FSM state enum (IDLE, EMIT, FINISH)
- One sub-module instance: the existing s_box (input_data/output_data), fed by key nibble w3. No new sub-module is required.
- Elaboration check: NUM_ROUNDS within 1..MAX_ROUNDS.

Test Plan:
- Reset then in_key=0xC3F0, start=1, rk_ready=1 held -> keys 0xC3F0 (idx0), 0x30FF (idx1), 0x6696 (idx2) on consecutive cycles; done pulses once the cycle after idx2; busy low afterwards.
- Same key with rk_ready toggling 1,0,0,1,... -> each key is held stable while rk_ready=0, no key is skipped or duplicated, and the same three values appear.
- start pulsed with in_key=0xFFFF while busy -> ignored; the sequence continues from the original key, with no extra done pulse.
- rst_n deasserted low while idx1 is presented -> all outputs return to reset values asynchronously; no rk_valid after release until a new start.
- NUM_ROUNDS=8, in_key=0x0000 -> nine keys emitted; bench reference model checks every value and that RCON 1,2,4,8,3,6,C,B was applied in order.
- Back-to-back runs: start accepted in the IDLE cycle after done -> the second run's K0 equals the new in_key and no output is carried over from the first run.

Source files
------------

// File: rtl/key_schedule_pkg.sv
// rtl/key_schedule_pkg.sv - shared constants, FSM states and round-constant lookup for key_schedule
package key_schedule_pkg;

    localparam int KEY_W      = 16;
    localparam int NIB_W      = 4;
    localparam int MAX_ROUNDS = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EMIT   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    // Successive powers of x in GF(2^4) mod x^4+x+1, indexed by round number 1..8.
    function automatic logic [NIB_W-1:0] rcon(input logic [NIB_W-1:0] n);
        logic [NIB_W-1:0] r;
        r = '0;
        case (n)
            4'd1:    r = 4'h1;
            4'd2:    r = 4'h2;
            4'd3:    r = 4'h4;
            4'd4:    r = 4'h8;
            4'd5:    r = 4'h3;
            4'd6:    r = 4'h6;
            4'd7:    r = 4'hC;
            4'd8:    r = 4'hB;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/s_box.sv
// rtl/s_box.sv - Mini-AES 4-bit substitution box
module s_box (
    input  logic [3:0] input_data,
    output logic [3:0] output_data
);

    // Table lookup, purely combinational.
    always_comb begin
        output_data = 4'h0;
        case (input_data)
            4'h0: output_data = 4'hE;
            4'h1: output_data = 4'h4;
            4'h2: output_data = 4'hD;
            4'h3: output_data = 4'h1;
            4'h4: output_data = 4'h2;
            4'h5: output_data = 4'hF;
            4'h6: output_data = 4'hB;
            4'h7: output_data = 4'h8;
            4'h8: output_data = 4'h3;
            4'h9: output_data = 4'hA;
            4'hA: output_data = 4'h6;
            4'hB: output_data = 4'hC;
            4'hC: output_data = 4'h5;
            4'hD: output_data = 4'h9;
            4'hE: output_data = 4'h0;
            4'hF: output_data = 4'h7;
            default: output_data = 4'h0;
        endcase
    end

endmodule

// File: rtl/key_schedule.sv
// rtl/key_schedule.sv - sequential Mini-AES round-key generator with valid/ready output
module key_schedule
    import key_schedule_pkg::*;
#(
    parameter int NUM_ROUNDS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] in_key,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] round_key,
    output logic [3:0]       round_idx,
    output logic             busy,
    output logic             done
);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > MAX_ROUNDS) begin : g_bad_num_rounds
        $error("key_schedule: NUM_ROUNDS must be within 1..MAX_ROUNDS");
    end

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    logic [1:0]       state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [3:0]       idx_q, idx_d;

    logic [NIB_W-1:0] w0, w1, w2, w3;
    logic [NIB_W-1:0] w4, w5, w6, w7;
    logic [NIB_W-1:0] sub_w3;
    logic [3:0]       next_round;

    assign {w0, w1, w2, w3} = key_q;
    assign next_round       = idx_q + 4'd1;

    s_box u_s_box (
        .input_data  (w3),
        .output_data (sub_w3)
    );

    // Next round key: one substitution on w3, then a running XOR chain across the nibbles.
    always_comb begin
        w4 = w0 ^ sub_w3 ^ rcon(next_round);
        w5 = w1 ^ w4;
        w6 = w2 ^ w5;
        w7 = w3 ^ w6;
    end

    // Sequencer: accept a start in IDLE, step one key per handshake, flag completion for one cycle.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = in_key;
                    idx_d   = 4'd0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (rk_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FINISH;
                    end else begin
                        key_d = {w4, w5, w6, w7};
                        idx_d = next_round;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, key and index registers; reset aborts any expansion in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
        end
    end

    assign rk_valid  = (state_q == ST_EMIT);
    assign busy      = (state_q == ST_EMIT);
    assign done      = (state_q == ST_FINISH);
    assign round_key = key_q;
    assign round_idx = idx_q;

endmodule

// File: tb/tb_key_schedule.sv
// tb/tb_key_schedule.sv - self-checking bench for key_schedule with a behavioural key-expansion model
module tb_key_schedule;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] in_key;
    logic        rk_ready;
    logic        sel8;

    logic        v2, v8, b2, b8, d2, d8;
    logic [15:0] k2, k8;
    logic [3:0]  i2, i8;

    logic        v, b, d;
    logic [15:0] k;
    logic [3:0]  idx;

    int checks = 0;
    int errors = 0;

    logic [3:0] sbox_tab [16];
    logic [3:0] rcon_ref [8];

    key_schedule #(.NUM_ROUNDS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start & ~sel8),
        .in_key    (in_key),
        .rk_valid  (v2),
        .rk_ready  (rk_ready & ~sel8),
        .round_key (k2),
        .round_idx (i2),
        .busy      (b2),
        .done      (d2)
    );

    key_schedule #(.NUM_ROUNDS(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start & sel8),
        .in_key    (in_key),
        .rk_valid  (v8),
        .rk_ready  (rk_ready & sel8),
        .round_key (k8),
        .round_idx (i8),
        .busy      (b8),
        .done      (d8)
    );

    assign v   = sel8 ? v8 : v2;
    assign b   = sel8 ? b8 : b2;
    assign d   = sel8 ? d8 : d2;
    assign k   = sel8 ? k8 : k2;
    assign idx = sel8 ? i8 : i2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference expansion straight from the key-schedule equations.
    function automatic logic [15:0] next_key(input logic [15:0] key, input int n);
        logic [3:0] w [8];
        w[0] = key[15:12]; w[1] = key[11:8]; w[2] = key[7:4]; w[3] = key[3:0];
        w[4] = w[0] ^ sbox_tab[w[3]] ^ rcon_ref[n-1];
        w[5] = w[1] ^ w[4];
        w[6] = w[2] ^ w[5];
        w[7] = w[3] ^ w[6];
        return {w[4], w[5], w[6], w[7]};
    endfunction

    // One full expansion run on the selected DUT. mode 0: ready always, 1: pattern 1,0,0,..., 2: random.
    task automatic run_seq(input logic [15:0] key, input int nr, input int mode, input bit inject);
        logic [15:0] expk [$];
        logic [15:0] prevk;
        int pos;
        int cyc;
        bit injected;
        logic [3:0] rc;
        expk.delete();
        expk.push_back(key);
        for (int n = 1; n <= nr; n++) expk.push_back(next_key(expk[n-1], n));
        start    = 1'b1;
        in_key   = key;
        rk_ready = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        in_key = $urandom;
        check("first_valid_latency", {31'd0, v}, 32'd1);
        pos = 0;
        cyc = 0;
        injected = 1'b0;
        prevk = key;
        while (pos <= nr && cyc < 200) begin
            check("rk_valid_hold", {31'd0, v}, 32'd1);
            check("busy_hold", {31'd0, b}, 32'd1);
            check("done_low", {31'd0, d}, 32'd0);
            check("round_key", {16'd0, k}, {16'd0, expk[pos]});
            check("round_idx", {28'd0, idx}, pos);
            if (pos > 0) begin
                rc = k[15:12] ^ prevk[15:12] ^ sbox_tab[prevk[3:0]];
                check("rcon_order", {28'd0, rc}, {28'd0, rcon_ref[pos-1]});
            end
            case (mode)
                0:       rk_ready = 1'b1;
                1:       rk_ready = (cyc % 3 == 0);
                default: rk_ready = $urandom_range(0, 1);
            endcase
            if (inject && !injected && pos == 1) begin
                start    = 1'b1;
                in_key   = 16'hFFFF;
                injected = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            if (rk_ready) begin
                prevk = expk[pos];
                pos++;
            end
            cyc++;
        end
        check("seq_completed_in_budget", pos, nr + 1);
        rk_ready = $urandom_range(0, 1);
        // FINISH cycle; a start here must be ignored.
        check("done_pulse", {31'd0, d}, 32'd1);
        check("busy_after_last", {31'd0, b}, 32'd0);
        check("valid_after_last", {31'd0, v}, 32'd0);
        start  = 1'b1;
        in_key = $urandom;
        @(negedge clk);
        start = 1'b0;
        check("done_single_cycle", {31'd0, d}, 32'd0);
        check("start_in_finish_ignored", {31'd0, v}, 32'd0);
        check("key_kept", {16'd0, k}, {16'd0, expk[nr]});
        check("idx_kept", {28'd0, idx}, nr);
    endtask

    initial begin
        logic [3:0] sb_init [16];
        logic [4:0] r;
        sb_init = '{4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
                    4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7};
        for (int i = 0; i < 16; i++) sbox_tab[i] = sb_init[i];
        r = 5'h1;
        for (int n = 0; n < 8; n++) begin
            rcon_ref[n] = r[3:0];
            r = r << 1;
            if (r[4]) r = r ^ 5'h13;
        end

        rst_n = 1'b0; start = 1'b0; in_key = 16'h0; rk_ready = 1'b0; sel8 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, v2}, 32'd0);
        check("rst_key", {16'd0, k2}, 32'd0);
        check("rst_idx", {28'd0, i2}, 32'd0);
        check("rst_busy", {31'd0, b2}, 32'd0);
        check("rst_done", {31'd0, d2}, 32'd0);
        check("rst_valid8", {31'd0, v8}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known vector with fixed expected keys.
        start = 1'b1; in_key = 16'hC3F0; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("kv_k0", {16'd0, k2}, 32'hC3F0);
        check("kv_i0", {28'd0, i2}, 32'd0);
        @(negedge clk);
        check("kv_k1", {16'd0, k2}, 32'h30FF);
        check("kv_i1", {28'd0, i2}, 32'd1);
        @(negedge clk);
        check("kv_k2", {16'd0, k2}, 32'h6696);
        check("kv_i2", {28'd0, i2}, 32'd2);
        @(negedge clk);
        check("kv_done", {31'd0, d2}, 32'd1);
        check("kv_busy", {31'd0, b2}, 32'd0);
        rk_ready = 1'b0;
        @(negedge clk);
        check("kv_done_off", {31'd0, d2}, 32'd0);
        @(negedge clk);

        run_seq(16'hC3F0, 2, 1, 1'b0);
        run_seq(16'hC3F0, 2, 2, 1'b1);
        for (int t = 0; t < 4; t++) run_seq(16'($urandom), 2, t % 3, 1'b0);

        // Asynchronous reset while idx1 is presented.
        start = 1'b1; in_key = 16'hC3F0; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rk_ready = 1'b0;
        check("pre_rst_idx1", {28'd0, i2}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, v2}, 32'd0);
        check("arst_key", {16'd0, k2}, 32'd0);
        check("arst_idx", {28'd0, i2}, 32'd0);
        check("arst_busy", {31'd0, b2}, 32'd0);
        check("arst_done", {31'd0, d2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rk_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("no_valid_after_rst", {31'd0, v2}, 32'd0);
        end

        // Back-to-back runs: second start lands in the IDLE cycle right after done.
        run_seq(16'h1234, 2, 0, 1'b0);
        run_seq(16'hBEEF, 2, 2, 1'b0);

        // Nine keys from NUM_ROUNDS=8.
        sel8 = 1'b1;
        @(negedge clk);
        run_seq(16'h0000, 8, 0, 1'b0);
        run_seq(16'($urandom), 8, 2, 1'b1);
        run_seq(16'($urandom), 8, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
